// File: rtl/decode_issue_pkg.sv
// ============================================================================
// Module      : decode_issue_pkg
// Description : Shared opcodes, ALU op-vector bit indices, instruction field
//               positions and the instruction decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package decode_issue_pkg;

    localparam int DATA_W   = 16;
    localparam int REG_W    = 3;
    localparam int IMM_W    = 5;
    localparam int OP_W     = 13;
    localparam int NUM_REGS = 8;

    localparam logic [REG_W-1:0] FLAG_REG = 3'd7;

    // Instruction field positions
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int I_BIT   = 11;
    localparam int RD_MSB  = 10;
    localparam int RD_LSB  = 8;
    localparam int RS1_MSB = 7;
    localparam int RS1_LSB = 5;
    localparam int RS2_MSB = 4;
    localparam int RS2_LSB = 2;
    localparam int IMM_MSB = 4;
    localparam int IMM_LSB = 0;

    typedef enum logic [3:0] {
        OPC_ADD     = 4'd0,
        OPC_LD      = 4'd1,
        OPC_ST      = 4'd2,
        OPC_SUB     = 4'd3,
        OPC_MUL     = 4'd4,
        OPC_CMP     = 4'd5,
        OPC_MOV     = 4'd6,
        OPC_OR      = 4'd7,
        OPC_AND     = 4'd8,
        OPC_NOT     = 4'd9,
        OPC_LSL     = 4'd10,
        OPC_LSR     = 4'd11,
        OPC_XOR     = 4'd12,
        OPC_NOP     = 4'd13,
        OPC_HALT    = 4'd14,
        OPC_ILLEGAL = 4'd15
    } opcode_e;

    // Bit positions inside the ALU one-hot operation vector
    localparam int ALU_ADD = 0;
    localparam int ALU_LD  = 1;
    localparam int ALU_ST  = 2;
    localparam int ALU_SUB = 3;
    localparam int ALU_MUL = 4;
    localparam int ALU_CMP = 5;
    localparam int ALU_MOV = 6;
    localparam int ALU_OR  = 7;
    localparam int ALU_AND = 8;
    localparam int ALU_NOT = 9;
    localparam int ALU_LSL = 10;
    localparam int ALU_LSR = 11;
    localparam int ALU_XOR = 12;

    typedef struct packed {
        logic             issues;
        logic             halt;
        logic [OP_W-1:0]  alu;
        logic             rs1_rd;
        logic             rs2_rd;
        logic             rdf_rd;
        logic             dst_wr;
        logic [REG_W-1:0] dst;
    } decode_t;

    function automatic decode_t decode(input logic [DATA_W-1:0] instr);
        decode_t d;
        opcode_e opc;
        logic    imm;
        opc    = opcode_e'(instr[OPC_MSB:OPC_LSB]);
        imm    = instr[I_BIT];
        d      = '0;
        d.dst  = instr[RD_MSB:RD_LSB];
        d.halt = (opc == OPC_HALT);
        if (opc <= OPC_XOR) begin
            d.issues = 1'b1;
            d.alu    = OP_W'(1) << 4'(opc);
            d.rs1_rd = (opc != OPC_MOV);
            d.rs2_rd = !imm && (opc != OPC_NOT) && (opc != OPC_LD) && (opc != OPC_ST);
            d.rdf_rd = (opc == OPC_ST);
            d.dst_wr = (opc != OPC_ST);
            if (opc == OPC_CMP) begin
                d.dst = FLAG_REG;
            end
        end
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/decode_issue_regfile_8x16.sv
// ============================================================================
// Module      : regfile_8x16
// Description : 8x16 register file, three read ports, one write port with
//               write-to-read forwarding and synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_8x16
    import decode_issue_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [REG_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [REG_W-1:0]  i_raddr1,
    output logic [DATA_W-1:0] o_rdata1,
    input  logic [REG_W-1:0]  i_raddr2,
    output logic [DATA_W-1:0] o_rdata2,
    input  logic [REG_W-1:0]  i_raddr3,
    output logic [DATA_W-1:0] o_rdata3
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // A writeback landing this cycle is visible to readers in the same cycle
    assign o_rdata1 = (i_we && (i_waddr == i_raddr1)) ? i_wdata : r_regs[i_raddr1];
    assign o_rdata2 = (i_we && (i_waddr == i_raddr2)) ? i_wdata : r_regs[i_raddr2];
    assign o_rdata3 = (i_we && (i_waddr == i_raddr3)) ? i_wdata : r_regs[i_raddr3];

endmodule

`default_nettype wire

// File: rtl/decode_issue.sv
// ============================================================================
// Module      : decode_issue
// Description : Decode/issue stage: decodes instructions, reads operands,
//               tracks in-flight destinations and issues into an output reg.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_issue
    import decode_issue_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_instr,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   alusignals,
    output logic [DATA_W-1:0] op1,
    output logic [DATA_W-1:0] op2,
    output logic [IMM_W-1:0]  immx,
    output logic              isimmediate,
    output logic [REG_W-1:0]  rd,
    output logic [DATA_W-1:0] stdata,
    input  logic              wb_en,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              halted
);

    decode_t             w_dec;
    logic [REG_W-1:0]    w_rs1;
    logic [REG_W-1:0]    w_rs2;
    logic [REG_W-1:0]    w_rdf;
    logic [DATA_W-1:0]   w_rs1_val;
    logic [DATA_W-1:0]   w_rs2_val;
    logic [DATA_W-1:0]   w_rdf_val;
    logic [NUM_REGS-1:0] w_clr;
    logic [NUM_REGS-1:0] w_busy_eff;
    logic [NUM_REGS-1:0] w_set;
    logic                w_hazard;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_issue;

    logic [NUM_REGS-1:0] r_busy;
    logic                r_out_valid;
    logic                r_halted;
    logic [OP_W-1:0]     r_alu;
    logic [DATA_W-1:0]   r_op1;
    logic [DATA_W-1:0]   r_op2;
    logic [IMM_W-1:0]    r_immx;
    logic                r_isimm;
    logic [REG_W-1:0]    r_rd;
    logic [DATA_W-1:0]   r_stdata;

    assign w_dec = decode(in_instr);
    assign w_rs1 = in_instr[RS1_MSB:RS1_LSB];
    assign w_rs2 = in_instr[RS2_MSB:RS2_LSB];
    assign w_rdf = in_instr[RD_MSB:RD_LSB];

    regfile_8x16 u_regfile (
        .clk      (clk),
        .rst      (rst),
        .i_we     (wb_en),
        .i_waddr  (wb_rd),
        .i_wdata  (wb_data),
        .i_raddr1 (w_rs1),
        .o_rdata1 (w_rs1_val),
        .i_raddr2 (w_rs2),
        .o_rdata2 (w_rs2_val),
        .i_raddr3 (w_rdf),
        .o_rdata3 (w_rdf_val)
    );

    // A register being written back this cycle no longer blocks issue
    assign w_clr      = wb_en ? (NUM_REGS'(1) << wb_rd) : '0;
    assign w_busy_eff = r_busy & ~w_clr;

    always_comb begin
        w_hazard = 1'b0;
        if (w_dec.rs1_rd && w_busy_eff[w_rs1]) w_hazard = 1'b1;
        if (w_dec.rs2_rd && w_busy_eff[w_rs2]) w_hazard = 1'b1;
        if (w_dec.rdf_rd && w_busy_eff[w_rdf]) w_hazard = 1'b1;
        if (w_dec.dst_wr && w_busy_eff[w_dec.dst]) w_hazard = 1'b1;
    end

    assign w_in_ready = !r_halted && !w_hazard && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready;
    assign w_issue    = w_accept && w_dec.issues;
    assign w_set      = (w_issue && w_dec.dst_wr) ? (NUM_REGS'(1) << w_dec.dst) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy      <= '0;
            r_out_valid <= 1'b0;
            r_halted    <= 1'b0;
            r_alu       <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_immx      <= '0;
            r_isimm     <= 1'b0;
            r_rd        <= '0;
            r_stdata    <= '0;
        end else begin
            // Set is OR'd after clear so a same-index issue keeps the bit busy
            r_busy <= w_busy_eff | w_set;
            if (w_accept && w_dec.halt) begin
                r_halted <= 1'b1;
            end
            if (w_issue) begin
                r_out_valid <= 1'b1;
                r_alu       <= w_dec.alu;
                r_op1       <= w_rs1_val;
                r_op2       <= w_rs2_val;
                r_immx      <= in_instr[IMM_MSB:IMM_LSB];
                r_isimm     <= in_instr[I_BIT];
                r_rd        <= w_dec.dst;
                r_stdata    <= w_rdf_val;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = r_out_valid;
    assign halted      = r_halted;
    assign alusignals  = r_alu;
    assign op1         = r_op1;
    assign op2         = r_op2;
    assign immx        = r_immx;
    assign isimmediate = r_isimm;
    assign rd          = r_rd;
    assign stdata      = r_stdata;

endmodule

`default_nettype wire
